// File: rtl/adder_result_collector.sv
// Collects pipelined adder {cout,sum} results into a FWFT FIFO and a running accumulator.
// Latency: accepted result visible at out_data one edge later; never stalls the adder (drops when full).
// Optional: define COLLECT_SAT_EN for a saturating accumulator instead of a wrapping one.

module adder_result_collector_fifo #(
  parameter int W     = 17,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       wr_vld,
  output logic                       wr_rdy,
  input  logic [W-1:0]               wr_dat,
  output logic                       rd_vld,
  input  logic                       rd_rdy,
  output logic [W-1:0]               rd_dat,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic                       empty
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [AW:0]   cnt;
  logic          pop;
  logic          push;

  assign full   = (cnt == (AW+1)'(DEPTH));
  assign empty  = (cnt == '0);
  assign rd_vld = !empty;
  assign rd_dat = mem[rd_ptr];
  assign count  = cnt;
  assign pop    = rd_vld & rd_rdy;
  // A full FIFO still takes a write when the head leaves on the same edge.
  assign wr_rdy = !full | pop;
  assign push   = wr_vld & wr_rdy;

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= wr_dat;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   cnt <= cnt + (AW+1)'(1);
        2'b01:   cnt <= cnt - (AW+1)'(1);
        default: cnt <= cnt;
      endcase
    end
  end
endmodule

module adder_result_collector #(
  parameter int WIDTH     = 16,
  parameter int DEPTH     = 4,
  parameter int ACC_WIDTH = 24
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       in_valid,
  input  logic [WIDTH-1:0]           in_sum,
  input  logic                       in_cout,
  input  logic                       clr,
  input  logic                       out_ready,
  output logic                       out_valid,
  output logic [WIDTH:0]             out_data,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic                       empty,
  output logic [ACC_WIDTH-1:0]       acc,
  output logic                       acc_ovf,
  output logic                       drop
);
  logic               wr_rdy;
  logic               accept;
  logic [WIDTH:0]     res_dat;
  logic [ACC_WIDTH:0] res_ext;
  logic [ACC_WIDTH:0] acc_sum;
  logic [ACC_WIDTH-1:0] acc_q;
  logic               ovf_q;
  logic               drop_q;

  assign res_dat = {in_cout, in_sum};
  assign accept  = in_valid & wr_rdy;
  assign res_ext = {{(ACC_WIDTH-WIDTH){1'b0}}, res_dat};
  assign acc_sum = {1'b0, acc_q} + res_ext;

  adder_result_collector_fifo #(
    .W     (WIDTH+1),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk    (clk),
    .reset  (reset),
    .wr_vld (in_valid),
    .wr_rdy (wr_rdy),
    .wr_dat (res_dat),
    .rd_vld (out_valid),
    .rd_rdy (out_ready),
    .rd_dat (out_data),
    .count  (count),
    .full   (full),
    .empty  (empty)
  );

  // clr wins over both accumulation and a same-cycle drop.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc_q  <= '0;
      ovf_q  <= 1'b0;
      drop_q <= 1'b0;
    end else if (clr) begin
      acc_q  <= '0;
      ovf_q  <= 1'b0;
      drop_q <= 1'b0;
    end else begin
      if (accept) begin
`ifdef COLLECT_SAT_EN
        if (acc_sum[ACC_WIDTH]) begin
          acc_q <= '1;
          ovf_q <= 1'b1;
        end else begin
          acc_q <= acc_sum[ACC_WIDTH-1:0];
        end
`else
        acc_q <= acc_sum[ACC_WIDTH-1:0];
        if (acc_sum[ACC_WIDTH]) ovf_q <= 1'b1;
`endif
      end
      if (in_valid && !accept) drop_q <= 1'b1;
    end
  end

  assign acc     = acc_q;
  assign acc_ovf = ovf_q;
  assign drop    = drop_q;
endmodule
